// File: rtl/mm_core_control_pkg.sv
// Shared types and register map for mm_core_control.
// Optional watchdog: MM_CORE_CONTROL_TIMEOUT_EN.
package mm_core_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned ADDR_CTRL     = 0;
    localparam int unsigned ADDR_CORE_EN  = 1;
    localparam int unsigned ADDR_STATUS   = 2;
    localparam int unsigned ADDR_IRQ_EN   = 3;
    localparam int unsigned ADDR_FINISHED = 4;
    localparam int unsigned ADDR_RUNTIME  = 5;

    localparam int unsigned STATUS_BUSY    = 0;
    localparam int unsigned STATUS_DONE    = 1;
    localparam int unsigned STATUS_OVERRUN = 2;
    localparam int unsigned STATUS_TIMEOUT = 3;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_ABORT = 1;

endpackage

// File: rtl/mm_reg_file.sv
// Register storage, sticky W1C flags and registered read mux.
// Timeout flag exists only with MM_CORE_CONTROL_TIMEOUT_EN.
module mm_reg_file #(
    parameter int NUM_CORES  = 4,
    parameter int WIDTH_CTRL = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [WIDTH_CTRL-1:0] wdata_i,
    output logic [WIDTH_CTRL-1:0] rdata_o,
    input  logic                  busy_i,
    input  logic                  set_done_i,
    input  logic                  set_overrun_i,
    input  logic                  set_timeout_i,
    input  logic [NUM_CORES-1:0]  finished_i,
    input  logic [WIDTH_CTRL-1:0] runtime_i,
    output logic [NUM_CORES-1:0]  core_en_o,
    output logic                  start_o,
    output logic                  abort_o,
    output logic                  irq_o
);
    import mm_core_control_pkg::*;

    logic [NUM_CORES-1:0]  core_en_q;
    logic                  irq_en_q;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_q;
    logic                  irq_q;
    logic [WIDTH_CTRL-1:0] rdata_q, rdata_d;
    logic                  wr_ctrl, wr_en, wr_stat, wr_irq;
    logic                  unused_wdata;

    assign wr_ctrl = write_i && (addr_i == ADDR_W'(ADDR_CTRL));
    assign wr_en   = write_i && (addr_i == ADDR_W'(ADDR_CORE_EN));
    assign wr_stat = write_i && (addr_i == ADDR_W'(ADDR_STATUS));
    assign wr_irq  = write_i && (addr_i == ADDR_W'(ADDR_IRQ_EN));

    // Abort in the same write as start cancels the start.
    assign start_o = wr_ctrl && wdata_i[CTRL_START] && !wdata_i[CTRL_ABORT];
    assign abort_o = wr_ctrl && wdata_i[CTRL_ABORT];

    assign done_d    = set_done_i
                     | (done_q & ~(wr_stat & wdata_i[STATUS_DONE]));
    assign overrun_d = set_overrun_i
                     | (overrun_q & ~(wr_stat & wdata_i[STATUS_OVERRUN]));

    assign unused_wdata = ^wdata_i;

`ifdef MM_CORE_CONTROL_TIMEOUT_EN
    logic timeout_d;

    assign timeout_d = set_timeout_i
                     | (timeout_q & ~(wr_stat & wdata_i[STATUS_TIMEOUT]));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_q      = 1'b0;
    assign unused_timeout = set_timeout_i;
`endif

    always_comb begin
        rdata_d = '0;
        case (addr_i)
            ADDR_W'(ADDR_CORE_EN):  rdata_d[NUM_CORES-1:0] = core_en_q;
            ADDR_W'(ADDR_STATUS): begin
                rdata_d[STATUS_BUSY]    = busy_i;
                rdata_d[STATUS_DONE]    = done_q;
                rdata_d[STATUS_OVERRUN] = overrun_q;
                rdata_d[STATUS_TIMEOUT] = timeout_q;
            end
            ADDR_W'(ADDR_IRQ_EN):   rdata_d[0] = irq_en_q;
            ADDR_W'(ADDR_FINISHED): rdata_d[NUM_CORES-1:0] = finished_i;
            ADDR_W'(ADDR_RUNTIME):  rdata_d = runtime_i;
            default:                rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            core_en_q <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (wr_en && !busy_i) begin
                core_en_q <= wdata_i[NUM_CORES-1:0];
            end
            if (wr_irq) begin
                irq_en_q <= wdata_i[0];
            end
            done_q    <= done_d;
            overrun_q <= overrun_d;
            irq_q     <= done_q & irq_en_q;
            if (read_i) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign core_en_o = core_en_q;
    assign irq_o     = irq_q;
    assign rdata_o   = rdata_q;

endmodule

// File: rtl/mm_core_control.sv
// Run sequencer for NUM_CORES videocard cores with HPS register port.
// Optional watchdog: define MM_CORE_CONTROL_TIMEOUT_EN.
module mm_core_control #(
    parameter int NUM_CORES      = 4,
    parameter int WIDTH_CTRL     = 8,
    parameter int ADDR_W         = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset_sink_reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  read,
    input  logic                  write,
    input  logic [WIDTH_CTRL-1:0] data_write,
    output logic [WIDTH_CTRL-1:0] data_read,
    input  logic [NUM_CORES-1:0]  core_finish,
    output logic [NUM_CORES-1:0]  core_en,
    output logic                  interrupt_start,
    output logic                  clear_interrupt,
    output logic                  irq
);
    import mm_core_control_pkg::*;

    state_e                state_q, state_d;
    logic [NUM_CORES-1:0]  finished_q, finished_d;
    logic [WIDTH_CTRL-1:0] runtime_q, runtime_d;
    logic [NUM_CORES-1:0]  en;
    logic                  start, abort, busy;
    logic                  set_done, set_overrun, set_timeout;
    logic                  pulse_q;
    logic                  wd_hit;

    assign busy = (state_q != ST_IDLE);

    mm_reg_file #(
        .NUM_CORES  (NUM_CORES),
        .WIDTH_CTRL (WIDTH_CTRL),
        .ADDR_W     (ADDR_W)
    ) u_regs (
        .clk_i         (clk),
        .rst_n_i       (reset_sink_reset),
        .addr_i        (address),
        .read_i        (read),
        .write_i       (write),
        .wdata_i       (data_write),
        .rdata_o       (data_read),
        .busy_i        (busy),
        .set_done_i    (set_done),
        .set_overrun_i (set_overrun),
        .set_timeout_i (set_timeout),
        .finished_i    (finished_q),
        .runtime_i     (runtime_q),
        .core_en_o     (en),
        .start_o       (start),
        .abort_o       (abort),
        .irq_o         (irq)
    );

`ifdef MM_CORE_CONTROL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Hit on the RUN cycle that completes TIMEOUT_CYCLES of running.
    assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_d = wd_q;
        if (state_q == ST_START) begin
            wd_d = '0;
        end else if (state_q == ST_RUN) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_sink_reset) begin
        if (!reset_sink_reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_cfg;

    assign wd_hit     = 1'b0;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d     = state_q;
        finished_d  = finished_q;
        runtime_d   = runtime_q;
        set_done    = 1'b0;
        set_overrun = start && busy;
        set_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (en != '0) begin
                        state_d = ST_START;
                    end else begin
                        set_done = 1'b1;
                    end
                end
            end
            ST_START: begin
                finished_d = '0;
                runtime_d  = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                finished_d = finished_q | (core_finish & en);
                runtime_d  = (&runtime_q) ? runtime_q : runtime_q + 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (finished_d == en) begin
                    state_d = ST_DONE;
                end else if (wd_hit) begin
                    state_d     = ST_DONE;
                    set_timeout = 1'b1;
                end
            end
            ST_DONE: begin
                set_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_sink_reset) begin
        if (!reset_sink_reset) begin
            state_q    <= ST_IDLE;
            finished_q <= '0;
            runtime_q  <= '0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            finished_q <= finished_d;
            runtime_q  <= runtime_d;
            pulse_q    <= (state_d == ST_START);
        end
    end

    assign core_en         = en;
    assign interrupt_start = pulse_q;
    assign clear_interrupt = pulse_q;

endmodule

// File: tb/tb_mm_core_control.sv
// Self-checking bench for mm_core_control with randomized runs.
// Build with MM_CORE_CONTROL_TIMEOUT_EN to exercise the watchdog.
module tb_mm_core_control;

    localparam int NC = 4;
    localparam int W  = 8;
    localparam int AW = 3;
`ifdef MM_CORE_CONTROL_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 65535;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [W-1:0]  data_write;
    logic [W-1:0]  data_read;
    logic [NC-1:0] core_finish;
    logic [NC-1:0] core_en;
    logic          interrupt_start;
    logic          clear_interrupt;
    logic          irq;

    int checks = 0;
    int fails  = 0;
    logic [NC-1:0] m_finished;

    mm_core_control #(
        .NUM_CORES      (NC),
        .WIDTH_CTRL     (W),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .reset_sink_reset (rst_n),
        .address          (address),
        .read             (read),
        .write            (write),
        .data_write       (data_write),
        .data_read        (data_read),
        .core_finish      (core_finish),
        .core_en          (core_en),
        .interrupt_start  (interrupt_start),
        .clear_interrupt  (clear_interrupt),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        address    = a;
        data_write = d;
        write      = 1'b1;
        tick();
        write      = 1'b0;
        data_write = '0;
    endtask

    task automatic reg_read(input logic [AW-1:0] a, output logic [W-1:0] d);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
        d       = data_read;
    endtask

    task automatic test_reset();
        logic [W-1:0] rd;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({core_en, interrupt_start, clear_interrupt, irq} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got en=%h is=%b ci=%b irq=%b exp all 0",
                     core_en, interrupt_start, clear_interrupt, irq);
        end
        checks++;
        if (data_read !== '0) begin
            fails++;
            $display("FAIL reset_data_read: got %h exp 00", data_read);
        end
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            reg_read(AW'(a), rd);
            checks++;
            if (rd !== 8'h00) begin
                fails++;
                $display("FAIL reset_reg%0d: got %h exp 00", a, rd);
            end
        end
        m_finished = '0;
    endtask

    task automatic test_reg_rw();
        logic [W-1:0] rd;
        logic [NC-1:0] v;
        reg_write(3'd3, 8'hFF);
        reg_read(3'd3, rd);
        checks++;
        if (rd !== 8'h01) begin
            fails++;
            $display("FAIL irq_en_rw: got %h exp 01", rd);
        end
        reg_write(3'd3, 8'h00);
        v = NC'($urandom);
        reg_write(3'd1, {4'($urandom), v});
        reg_read(3'd1, rd);
        checks++;
        if (rd !== {4'h0, v}) begin
            fails++;
            $display("FAIL core_en_rw: got %h exp %h", rd, {4'h0, v});
        end
        checks++;
        if (core_en !== v) begin
            fails++;
            $display("FAIL core_en_port: got %h exp %h", core_en, v);
        end
        reg_read(3'd0, rd);
        checks++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL ctrl_read: got %h exp 00", rd);
        end
        reg_write(3'd6, 8'hFF);
        reg_read(3'd6, rd);
        checks++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL addr6_read: got %h exp 00", rd);
        end
        reg_write(3'd1, 8'h00);
    endtask

    task automatic test_random_runs();
        logic [W-1:0] rd;
        logic [NC-1:0] mask, cf;
        logic ie;
        int kk[NC];
        int r;
        for (int it = 0; it < 8; it++) begin
            mask = NC'($urandom_range(1, 15));
            ie   = 1'($urandom_range(0, 1));
            reg_write(3'd1, {4'h0, mask});
            reg_write(3'd3, {7'h0, ie});
            repeat (3) begin
                core_finish = NC'($urandom);
                tick();
            end
            reg_read(3'd4, rd);
            core_finish = '0;
            checks++;
            if (rd[NC-1:0] !== m_finished) begin
                fails++;
                $display("FAIL idle_finish_ignored: got %h exp %h", rd, m_finished);
            end
            r = 0;
            for (int i = 0; i < NC; i++) begin
                kk[i] = mask[i] ? int'($urandom_range(1, 12)) : 0;
                if (kk[i] > r) r = kk[i];
            end
            reg_write(3'd0, 8'h01);
            checks++;
            if ({interrupt_start, clear_interrupt} !== 2'b11) begin
                fails++;
                $display("FAIL start_pulse: got %b%b exp 11",
                         interrupt_start, clear_interrupt);
            end
            tick();
            checks++;
            if (interrupt_start !== 1'b0) begin
                fails++;
                $display("FAIL start_pulse_width: got %b exp 0", interrupt_start);
            end
            for (int k = 1; k <= r; k++) begin
                cf = NC'($urandom) & ~mask;
                for (int i = 0; i < NC; i++) begin
                    if (mask[i] && (k == kk[i] || (k > kk[i] && $urandom_range(0, 1) == 1)))
                        cf[i] = 1'b1;
                end
                core_finish = cf;
                tick();
            end
            core_finish = NC'($urandom);
            reg_read(3'd2, rd);
            core_finish = '0;
            checks++;
            if (rd !== 8'h01) begin
                fails++;
                $display("FAIL run_done_cycle_status: got %h exp 01", rd);
            end
            checks++;
            if (irq !== 1'b0) begin
                fails++;
                $display("FAIL irq_early: got %b exp 0", irq);
            end
            reg_read(3'd2, rd);
            checks++;
            if (rd !== 8'h02) begin
                fails++;
                $display("FAIL run_status: got %h exp 02", rd);
            end
            checks++;
            if (irq !== ie) begin
                fails++;
                $display("FAIL run_irq: got %b exp %b", irq, ie);
            end
            m_finished = mask;
            reg_read(3'd4, rd);
            checks++;
            if (rd !== {4'h0, mask}) begin
                fails++;
                $display("FAIL run_finished: got %h exp %h", rd, {4'h0, mask});
            end
            reg_read(3'd5, rd);
            checks++;
            if (rd !== W'(r)) begin
                fails++;
                $display("FAIL run_runtime: got %0d exp %0d", rd, r);
            end
            reg_write(3'd2, 8'h0E);
            tick();
            checks++;
            if (irq !== 1'b0) begin
                fails++;
                $display("FAIL irq_w1c: got %b exp 0", irq);
            end
            reg_read(3'd2, rd);
            checks++;
            if (rd !== 8'h00) begin
                fails++;
                $display("FAIL run_status_clr: got %h exp 00", rd);
            end
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] rd;
        reg_write(3'd1, 8'h03);
        reg_write(3'd0, 8'h01);
        tick();
        reg_write(3'd0, 8'h01);
        checks++;
        if (interrupt_start !== 1'b0) begin
            fails++;
            $display("FAIL overrun_no_restart: got %b exp 0", interrupt_start);
        end
        reg_write(3'd1, 8'h0F);
        checks++;
        if (core_en !== 4'h3) begin
            fails++;
            $display("FAIL core_en_busy_write: got %h exp 3", core_en);
        end
        core_finish = 4'h3;
        tick();
        core_finish = '0;
        tick();
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h06) begin
            fails++;
            $display("FAIL overrun_status: got %h exp 06", rd);
        end
        reg_read(3'd5, rd);
        checks++;
        if (rd !== 8'd3) begin
            fails++;
            $display("FAIL overrun_runtime: got %0d exp 3", rd);
        end
        m_finished = 4'h3;
        reg_write(3'd2, 8'h06);
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL overrun_clr: got %h exp 00", rd);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] rd;
        reg_write(3'd3, 8'h01);
        reg_write(3'd1, 8'h0F);
        reg_write(3'd0, 8'h01);
        tick();
        core_finish = 4'h2;
        tick();
        core_finish = '0;
        repeat (2) tick();
        reg_write(3'd0, 8'h02);
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL abort_status: got %h exp 00", rd);
        end
        reg_read(3'd4, rd);
        checks++;
        if (rd !== 8'h02) begin
            fails++;
            $display("FAIL abort_finished: got %h exp 02", rd);
        end
        m_finished = 4'h2;
        repeat (3) tick();
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h00 || irq !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: got status %h irq %b exp 00 0", rd, irq);
        end
    endtask

    task automatic test_start_abort();
        logic [W-1:0] rd;
        reg_write(3'd0, 8'h03);
        checks++;
        if (interrupt_start !== 1'b0) begin
            fails++;
            $display("FAIL start_abort_pulse: got %b exp 0", interrupt_start);
        end
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL start_abort_status: got %h exp 00", rd);
        end
        reg_read(3'd4, rd);
        checks++;
        if (rd[NC-1:0] !== m_finished) begin
            fails++;
            $display("FAIL start_abort_finished: got %h exp %h", rd, m_finished);
        end
    endtask

    task automatic test_zero_mask();
        logic [W-1:0] rd;
        reg_write(3'd1, 8'h00);
        core_finish = 4'hF;
        reg_write(3'd0, 8'h01);
        checks++;
        if (interrupt_start !== 1'b0) begin
            fails++;
            $display("FAIL zero_mask_pulse: got %b exp 0", interrupt_start);
        end
        reg_read(3'd2, rd);
        core_finish = '0;
        checks++;
        if (rd !== 8'h02) begin
            fails++;
            $display("FAIL zero_mask_status: got %h exp 02", rd);
        end
        reg_write(3'd2, 8'h02);
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL zero_mask_clr: got %h exp 00", rd);
        end
    endtask

    task automatic test_set_wins();
        logic [W-1:0] rd;
        reg_write(3'd1, 8'h01);
        reg_write(3'd0, 8'h01);
        tick();
        core_finish = 4'h1;
        tick();
        core_finish = '0;
        reg_write(3'd2, 8'h02);
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h02) begin
            fails++;
            $display("FAIL set_wins_status: got %h exp 02", rd);
        end
        reg_read(3'd5, rd);
        checks++;
        if (rd !== 8'd1) begin
            fails++;
            $display("FAIL set_wins_runtime: got %0d exp 1", rd);
        end
        m_finished = 4'h1;
        reg_write(3'd2, 8'h02);
    endtask

`ifndef MM_CORE_CONTROL_TIMEOUT_EN
    task automatic test_saturate();
        logic [W-1:0] rd;
        reg_write(3'd1, 8'h01);
        reg_write(3'd0, 8'h01);
        tick();
        repeat (299) tick();
        core_finish = 4'h1;
        tick();
        core_finish = '0;
        tick();
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h02) begin
            fails++;
            $display("FAIL saturate_status: got %h exp 02", rd);
        end
        reg_read(3'd5, rd);
        checks++;
        if (rd !== 8'hFF) begin
            fails++;
            $display("FAIL saturate_runtime: got %h exp FF", rd);
        end
        m_finished = 4'h1;
        reg_write(3'd2, 8'h02);
    endtask
`else
    task automatic test_timeout();
        logic [W-1:0] rd;
        reg_write(3'd1, 8'h01);
        reg_write(3'd0, 8'h01);
        repeat (18) tick();
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h0A) begin
            fails++;
            $display("FAIL timeout_status: got %h exp 0A", rd);
        end
        reg_write(3'd2, 8'h0A);
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL timeout_clr: got %h exp 00", rd);
        end
    endtask
`endif

    task automatic test_reset_midrun();
        logic [W-1:0] rd;
        reg_write(3'd1, 8'h03);
        reg_write(3'd0, 8'h01);
        tick();
        core_finish = 4'h1;
        tick();
        core_finish = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({core_en, interrupt_start, irq} !== '0 || data_read !== '0) begin
            fails++;
            $display("FAIL midrun_reset: got en=%h is=%b irq=%b rd=%h exp 0",
                     core_en, interrupt_start, irq, data_read);
        end
        tick();
        rst_n = 1'b1;
        tick();
        reg_read(3'd2, rd);
        checks++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL midrun_reset_status: got %h exp 00", rd);
        end
        reg_read(3'd4, rd);
        checks++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL midrun_reset_finished: got %h exp 00", rd);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        address     = '0;
        read        = 1'b0;
        write       = 1'b0;
        data_write  = '0;
        core_finish = '0;
        m_finished  = '0;
        test_reset();
        test_reg_rw();
        test_random_runs();
        test_overrun();
        test_abort();
        test_start_abort();
        test_zero_mask();
        test_set_wins();
`ifndef MM_CORE_CONTROL_TIMEOUT_EN
        test_saturate();
`else
        test_timeout();
`endif
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
